// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared constants and the single decode function used by both the
// combinational outputs and the registered one-hot copy, so the two paths can
// never disagree about which output belongs to which select code.
//   SEL_W   : width of the binary select code
//   N_OUT   : number of decoded outputs
//   onehot4 : 2-bit select -> 4-bit one-hot (bit i high when sel == i)
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int SEL_W = 2;
    localparam int N_OUT = 4;

    // Every 0/1 select value is enumerated, so synthesis sees a full one-hot
    // decode; the default branch is only reachable in simulation when sel
    // carries X/Z, and then it propagates X to every output.
    function automatic logic [N_OUT-1:0] onehot4(input logic [SEL_W-1:0] sel);
        case (sel)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            2'b11:   return 4'b1000;
            default: return 4'bxxxx;
        endcase
    endfunction

endpackage

// File: rtl/decoder_2to4_if.sv
// -----------------------------------------------------------------------------
// decoder_2to4_if
// Bundle of the select input and all decoder outputs.
//   sel     : binary select code (driven by master)
//   y0..y3  : combinational one-hot decode of sel
//   y_q     : registered one-hot decode, bit i mirrors yi one cycle later
//   sel_chg : one-cycle pulse when the registered select changed value
//   hit_cnt : packed saturating per-output hit counters, CNT_W bits each
// master = the block driving sel, slave = the decoder.
// -----------------------------------------------------------------------------
interface decoder_2to4_if #(
    parameter int CNT_W = 8
);
    import decoder_pkg::*;

    logic [SEL_W-1:0]       sel;
    logic                   y0;
    logic                   y1;
    logic                   y2;
    logic                   y3;
    logic [N_OUT-1:0]       y_q;
    logic                   sel_chg;
    logic [N_OUT*CNT_W-1:0] hit_cnt;

    modport master (
        output sel,
        input  y0, y1, y2, y3, y_q, sel_chg, hit_cnt
    );

    modport slave (
        input  sel,
        output y0, y1, y2, y3, y_q, sel_chg, hit_cnt
    );

endinterface

// File: rtl/decoder_hit_counter.sv
// -----------------------------------------------------------------------------
// decoder_hit_counter
// Saturating up-counter: increments by one on each clock with inc high and
// sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current count value
// -----------------------------------------------------------------------------
module decoder_hit_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/decoder_2to4.sv
// -----------------------------------------------------------------------------
// decoder_2to4
// 2-to-4 one-hot decoder with a registered copy of the decode, a select-change
// pulse and per-output saturating hit counters.
//   clk     : rising-edge clock for all registered logic
//   rst     : synchronous active-high reset (does not touch y0..y3)
//   bus     : slave side of decoder_2to4_if (sel in; y0..y3, y_q, sel_chg,
//             hit_cnt out)
// Parameters:
//   CNT_W   : width of each hit counter (must match the interface's CNT_W)
//   REG_OUT : 1 = drive registered y_q, 0 = y_q tied low
// -----------------------------------------------------------------------------
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    decoder_2to4_if.slave  bus
);

    logic [N_OUT-1:0]       w_y;
    logic [N_OUT*CNT_W-1:0] w_hit_cnt;

    logic [SEL_W-1:0]       r_sel_q;
    logic                   r_first;
    logic                   r_sel_chg;

    // Combinational decode: zero latency, independent of clk and rst.
    assign w_y    = onehot4(bus.sel);
    assign bus.y0 = w_y[0];
    assign bus.y1 = w_y[1];
    assign bus.y2 = w_y[2];
    assign bus.y3 = w_y[3];

    // Select capture and change detection. The pulse is registered together
    // with the new sel_q, so it is high for the cycle right after sel_q moved.
    // r_first masks the comparison against the reset value of sel_q, so the
    // first capture after reset never reports a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q   <= '0;
            r_first   <= 1'b1;
            r_sel_chg <= 1'b0;
        end else begin
            r_sel_q   <= bus.sel;
            r_first   <= 1'b0;
            r_sel_chg <= !r_first && (bus.sel != r_sel_q);
        end
    end

    assign bus.sel_chg = r_sel_chg;

    generate
        if (REG_OUT) begin : gen_reg_out
            logic [N_OUT-1:0] r_y_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_y_q <= '0;
                end else begin
                    r_y_q <= onehot4(bus.sel);
                end
            end

            assign bus.y_q = r_y_q;
        end else begin : gen_no_reg_out
            assign bus.y_q = '0;
        end
    endgenerate

    // One counter per output, bumped in every cycle its output is selected.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : gen_hit_cnt
            decoder_hit_counter #(
                .CNT_W (CNT_W)
            ) u_hit_counter (
                .clk   (clk),
                .rst   (rst),
                .inc   (w_y[gi]),
                .count (w_hit_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign bus.hit_cnt = w_hit_cnt;

endmodule

// File: tb/tb_decoder_2to4.sv
// -----------------------------------------------------------------------------
// tb_decoder_2to4
// Two decoders (8-bit and 3-bit hit counters) share clk/rst and see the same
// select sequence. A behavioural model tracks expected hit counts, the
// registered decode and the select-change pulse per clock edge.
// -----------------------------------------------------------------------------
module tb_decoder_2to4;
    import decoder_pkg::*;

    logic clk = 1'b0;
    bit   clk_en = 1'b0;
    logic rst = 1'b0;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    decoder_2to4_if #(.CNT_W(8)) bus8 ();
    decoder_2to4_if #(.CNT_W(3)) bus3 ();

    decoder_2to4 #(.CNT_W(8), .REG_OUT(1'b1)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    decoder_2to4 #(.CNT_W(3), .REG_OUT(1'b1)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         cnt8 [4];
    int         cnt3 [4];
    logic [1:0] m_prev;
    bit         m_first;
    logic [3:0] exp_yq;
    logic       exp_chg;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] exp_y0first;   // {y0,y1,y2,y3}
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_sel(input logic [1:0] s);
        bus8.sel = s;
        bus3.sel = s;
    endtask

    task automatic compare_all();
        logic [31:0] e8;
        logic [11:0] e3;
        logic [3:0]  ey;
        for (int i = 0; i < 4; i++) begin
            e8[i*8 +: 8] = 8'(cnt8[i]);
            e3[i*3 +: 3] = 3'(cnt3[i]);
        end
        ey = 4'b0001 << bus8.sel;
        check("y_q_w8",     bus8.y_q,     exp_yq);
        check("y_q_w3",     bus3.y_q,     exp_yq);
        check("sel_chg_w8", bus8.sel_chg, exp_chg);
        check("sel_chg_w3", bus3.sel_chg, exp_chg);
        check("hit_cnt_w8", bus8.hit_cnt, e8);
        check("hit_cnt_w3", bus3.hit_cnt, e3);
        check("y_comb",     {bus8.y3, bus8.y2, bus8.y1, bus8.y0}, ey);
    endtask

    // One clock edge: advance the model with the values present at the edge,
    // then compare shortly after the edge.
    task automatic tick();
        logic [1:0] s;
        @(posedge clk);
        s = bus8.sel;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt8[i] = 0;
                cnt3[i] = 0;
            end
            m_first = 1'b1;
            m_prev  = 2'b00;
            exp_yq  = 4'b0000;
            exp_chg = 1'b0;
        end else begin
            exp_yq  = 4'b0001 << s;
            exp_chg = !m_first && (s != m_prev);
            m_prev  = s;
            m_first = 1'b0;
            if (cnt8[s] < 255) cnt8[s] = cnt8[s] + 1;
            if (cnt3[s] < 7)   cnt3[s] = cnt3[s] + 1;
        end
        #1;
        compare_all();
        $display("tick t=%0t rst=%0b sel=%0d y_q=%b sel_chg=%0b hit8=%h hit3=%h",
                 $time, rst, bus8.sel, bus8.y_q, bus8.sel_chg, bus8.hit_cnt, bus3.hit_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pulses;
        logic [5:0] pulse_mask;
        logic [1:0] seq [6];
        logic [31:0] h8;
        logic [11:0] h3;

        // Combinational decode with the clock idle
        vecs[0] = '{2'b00, 4'b1000};
        vecs[1] = '{2'b01, 4'b0100};
        vecs[2] = '{2'b10, 4'b0010};
        vecs[3] = '{2'b11, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            set_sel(vecs[i].sel);
            #1;
            check($sformatf("comb_table_%0d", i),
                  {bus8.y0, bus8.y1, bus8.y2, bus8.y3}, vecs[i].exp_y0first);
            check($sformatf("comb_table_w3_%0d", i),
                  {bus3.y0, bus3.y1, bus3.y2, bus3.y3}, vecs[i].exp_y0first);
            $display("comb sel=%0d y0..y3=%b%b%b%b", vecs[i].sel, bus8.y0, bus8.y1, bus8.y2, bus8.y3);
            #9;
        end

        clk_en = 1'b1;

        // Reset state; outputs y follow sel during reset
        rst = 1'b1;
        set_sel(2'b01);
        tick();
        set_sel(2'b11);
        tick();

        // Two reset cycles, then sel=10 held for 3 cycles
        set_sel(2'b00);
        tick();
        tick();
        rst = 1'b0;
        set_sel(2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold10_y_q", bus8.y_q, 4'b0100);
        end
        h8 = bus8.hit_cnt;
        check("hold10_cnt2", h8[23:16], 8'd3);
        check("hold10_cnt_other", {h8[31:24], h8[15:0]}, 24'd0);

        // sel change pulses: 00,00,01,01,11 then hold 11
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seq[0] = 2'b00; seq[1] = 2'b00; seq[2] = 2'b01;
        seq[3] = 2'b01; seq[4] = 2'b11; seq[5] = 2'b11;
        pulses = 0;
        pulse_mask = '0;
        for (int i = 0; i < 6; i++) begin
            set_sel(seq[i]);
            tick();
            if (bus8.sel_chg === 1'b1) begin
                pulses++;
                pulse_mask[i] = 1'b1;
            end
        end
        check("chg_pulse_count", pulses, 2);
        check("chg_pulse_pos", pulse_mask, 6'b010100);

        // First capture after reset with sel != 00 must not pulse
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_sel(2'b10);
        tick();
        check("first_capture_no_chg", bus8.sel_chg, 1'b0);

        // 3-bit counter saturation holding sel=01
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_sel(2'b01);
        for (int i = 0; i < 10; i++) tick();
        h3 = bus3.hit_cnt;
        check("sat3_cnt1", h3[5:3], 3'd7);
        tick();
        h3 = bus3.hit_cnt;
        check("sat3_cnt1_hold", h3[5:3], 3'd7);

        // sel=11 for 5 cycles, then reset while sel=11
        set_sel(2'b11);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sel11_y3", bus8.y3, 1'b1);
        end
        rst = 1'b1;
        #1;
        check("rst_y3_before_edge", bus8.y3, 1'b1);
        tick();
        check("rst_cnt_clear", bus8.hit_cnt, 32'd0);
        check("rst_y_q_clear", bus8.y_q, 4'b0000);
        check("rst_y3_hold", bus8.y3, 1'b1);
        rst = 1'b0;

        // 8-bit saturation, then reset of a saturated counter
        set_sel(2'b00);
        for (int i = 0; i < 260; i++) tick();
        h8 = bus8.hit_cnt;
        check("sat8_cnt0", h8[7:0], 8'd255);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomised traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            set_sel(2'($urandom_range(0, 3)));
            rst = ($urandom_range(0, 19) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
